// File: rtl/load_exec_unit.sv
// load_exec_unit
//   Executes one load at a time from the load buffer: issues an 8-byte
//   aligned memory request, waits for the 64-bit response, extracts and
//   extends the addressed byte/halfword/word, then broadcasts the result on
//   the CDB. A squash abandons the load at any point; a response that is
//   still owed to the memory system after a squash is drained and dropped.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   lb_read_mem              load buffer has a load ready
//   lb_address/_rob_tag/_mem_size  load byte address, ROB tag, funct3
//   lb_exec_stall            load not accepted this cycle
//   squash                   mispredict flush
//   mem_req/mem_addr/mem_gnt memory request handshake (8-byte aligned addr)
//   mem_rvalid/mem_rdata     64-bit memory response
//   cdb_valid/cdb_tag/cdb_value/cdb_grant  CDB broadcast handshake
module load_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lb_read_mem,
    input  logic [XLEN-1:0]  lb_address,
    input  logic [TAG_W-1:0] lb_rob_tag,
    input  logic [2:0]       lb_mem_size,
    output logic             lb_exec_stall,
    input  logic             squash,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [63:0]      mem_rdata,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_value,
    input  logic             cdb_grant
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        BCAST,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    addr_q,  addr_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;
    logic [2:0]         size_q,  size_d;
    logic [63:0]        data_q,  data_d;

    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        word_sel;
    logic [XLEN-1:0]    ext_value;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tag_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            size_q  <= size_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        size_d  = size_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (lb_read_mem && !squash) begin
                    addr_d  = lb_address;
                    tag_d   = lb_rob_tag;
                    size_d  = lb_mem_size;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A squash coinciding with a grant still leaves a response in
                // flight, so it must be drained rather than dropped.
                if (squash) begin
                    state_d = mem_gnt ? DRAIN : IDLE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (squash) begin
                    state_d = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = BCAST;
                end
            end
            BCAST: begin
                if (squash || cdb_grant) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane selection uses only the offset bits at or above the access size,
    // so misaligned low bits are silently ignored.
    assign byte_sel = data_q[{addr_q[2:0], 3'b000} +: 8];
    assign half_sel = data_q[{addr_q[2:1], 4'b0000} +: 16];
    assign word_sel = data_q[{addr_q[2], 5'b00000} +: 32];

    always_comb begin
        case (size_q)
            3'b000:  ext_value = XLEN'($signed(byte_sel));
            3'b001:  ext_value = XLEN'($signed(half_sel));
            3'b100:  ext_value = XLEN'(byte_sel);
            3'b101:  ext_value = XLEN'(half_sel);
            default: ext_value = XLEN'($signed(word_sel));
        endcase
    end

    assign lb_exec_stall = (state_q != IDLE) || squash;
    assign mem_req       = (state_q == REQ);
    assign mem_addr      = {addr_q[XLEN-1:3], 3'b000};
    assign cdb_valid     = (state_q == BCAST);
    assign cdb_tag       = tag_q;
    assign cdb_value     = ext_value;

endmodule

// File: tb/tb_load_exec_unit.sv
module tb_load_exec_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             lb_read_mem;
    logic [XLEN-1:0]  lb_address;
    logic [TAG_W-1:0] lb_rob_tag;
    logic [2:0]       lb_mem_size;
    logic             lb_exec_stall;
    logic             squash;
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [63:0]      mem_rdata;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_grant;

    load_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .lb_read_mem(lb_read_mem), .lb_address(lb_address),
        .lb_rob_tag(lb_rob_tag), .lb_mem_size(lb_mem_size),
        .lb_exec_stall(lb_exec_stall), .squash(squash),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_grant(cdb_grant)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: extracted value from plain arithmetic on the 64-bit line.
    function automatic logic [31:0] model_ext(input logic [63:0] d, input logic [31:0] a,
                                              input logic [2:0] sz);
        longint unsigned v;
        int unsigned off;
        off = a % 8;
        case (sz)
            3'b000, 3'b100: begin
                v = (d >> (off * 8)) & 64'hFF;
                if (sz == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = (d >> ((off / 2) * 16)) & 64'hFFFF;
                if (sz == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = (d >> ((off / 4) * 32)) & 64'hFFFF_FFFF;
        endcase
        return v[31:0];
    endfunction

    // Transaction-level model of the single outstanding load.
    bit          m_busy, m_issued, m_data, m_killed;
    logic [31:0] m_addr, m_val;
    logic [4:0]  m_tag;
    logic [2:0]  m_size;
    int          m_done   = 0;
    int          dut_done = 0;

    always @(posedge clock) begin
        if (!reset && cdb_valid && cdb_grant) dut_done++;
        if (reset) begin
            m_busy = 0; m_issued = 0; m_data = 0; m_killed = 0;
        end else if (m_killed) begin
            if (mem_rvalid) m_killed = 0;
        end else if (!m_busy) begin
            if (lb_read_mem && !squash) begin
                m_busy = 1; m_issued = 0; m_data = 0;
                m_addr = lb_address; m_tag = lb_rob_tag; m_size = lb_mem_size;
            end
        end else if (!m_issued) begin
            if (squash) begin
                m_busy = 0; m_killed = mem_gnt;
            end else if (mem_gnt) m_issued = 1;
        end else if (!m_data) begin
            if (mem_rvalid) begin
                if (squash) m_busy = 0;
                else begin
                    m_data = 1; m_val = model_ext(mem_rdata, m_addr, m_size);
                end
            end else if (squash) begin
                m_busy = 0; m_killed = 1;
            end
        end else if (squash || cdb_grant) begin
            m_busy = 0;
            if (cdb_grant) m_done++;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("stall", lb_exec_stall, m_busy || m_killed || squash);
            check("mem_req", mem_req, m_busy && !m_issued);
            check("cdb_valid", cdb_valid, m_busy && m_data);
            if (m_busy && !m_issued) check("mem_addr", mem_addr, m_addr & ~32'h7);
            if (m_busy && m_data) begin
                check("cdb_tag", cdb_tag, m_tag);
                check("cdb_value", cdb_value, m_val);
            end
        end
    end

    task automatic cyc(input logic rd, input logic [31:0] a, input logic [4:0] t,
                       input logic [2:0] sz, input logic sq, input logic g,
                       input logic rv, input logic [63:0] rdat, input logic cg);
        @(posedge clock);
        #2;
        lb_read_mem = rd; lb_address = a; lb_rob_tag = t; lb_mem_size = sz;
        squash = sq; mem_gnt = g; mem_rvalid = rv; mem_rdata = rdat; cdb_grant = cg;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 64'h0, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [4:0] t, input logic [2:0] sz,
                           input logic [63:0] rdat, input int gd, input int cd,
                           input logic [31:0] expv);
        cyc(1, a, t, sz, 0, 0, 0, 64'h0, 0);
        check("accept_stall", lb_exec_stall, 1'b0);
        for (int i = 0; i < gd; i++) begin
            cyc(1, a + 8, t + 5'd1, sz, 0, 0, 0, 64'h0, 0);
            check("bp_mem_req", mem_req, 1'b1);
            check("bp_mem_addr", mem_addr, a & ~32'h7);
            check("bp_stall", lb_exec_stall, 1'b1);
        end
        cyc(0, a, t, sz, 0, 1, 0, 64'h0, 0);
        check("req_mem_req", mem_req, 1'b1);
        check("req_mem_addr", mem_addr, a & ~32'h7);
        cyc(0, a, t, sz, 0, 0, 1, rdat, 0);
        check("wait_no_cdb", cdb_valid, 1'b0);
        for (int i = 0; i < cd; i++) begin
            cyc(1, a + 16, t + 5'd2, sz, 0, 0, 0, 64'h0, 0);
            check("bp_cdb_valid", cdb_valid, 1'b1);
            check("bp_cdb_tag", cdb_tag, t);
            check("bp_cdb_value", cdb_value, expv);
            check("bp_cdb_stall", lb_exec_stall, 1'b1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 64'h0, 1);
        check("bcast_valid", cdb_valid, 1'b1);
        check("bcast_tag", cdb_tag, t);
        check("bcast_value", cdb_value, expv);
        idle();
        check("after_valid", cdb_valid, 1'b0);
        check("after_stall", lb_exec_stall, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    initial begin
        reset = 1; lb_read_mem = 0; lb_address = 0; lb_rob_tag = 0; lb_mem_size = 0;
        squash = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; cdb_grant = 0;
        repeat (3) @(posedge clock);
        #2 reset = 0;
        #1 chk_en = 1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_cdb_valid", cdb_valid, 1'b0);
        check("rst_cdb_tag", cdb_tag, 5'd0);
        check("rst_cdb_value", cdb_value, 32'h0);
        check("rst_stall", lb_exec_stall, 1'b0);

        // Pin the model's extraction against hand-computed results.
        check("model_lb", model_ext(64'h0000_0000_8000_0000, 32'h1003, 3'b000), 32'hFFFF_FF80);
        check("model_lhu", model_ext(64'h8001_0000_0000_0000, 32'h2006, 3'b101), 32'h0000_8001);

        // LB, first with the exact address literal
        cyc(1, 32'h1003, 5'd7, 3'b000, 0, 0, 0, 64'h0, 0);
        cyc(0, 32'h1003, 5'd7, 3'b000, 0, 1, 0, 64'h0, 0);
        check("lb_mem_addr", mem_addr, 32'h1000);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_8000_0000, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 64'h0, 1);
        check("lb_tag", cdb_tag, 5'd7);
        check("lb_value", cdb_value, 32'hFFFF_FF80);
        idle();

        do_load(32'h2006, 5'd1, 3'b101, 64'h8001_0000_0000_0000, 0, 0, 32'h0000_8001);
        do_load(32'h2004, 5'd2, 3'b010, 64'hDEAD_BEEF_0000_0000, 0, 0, 32'hDEAD_BEEF);
        do_load(32'h3002, 5'd3, 3'b001, 64'h1122_3344_F234_5566, 3, 2, 32'hFFFF_F234);
        do_load(32'h4005, 5'd4, 3'b100, 64'h0000_9A00_0000_0000, 0, 1, 32'h0000_009A);
        do_load(32'h5004, 5'd5, 3'b110, 64'hCAFE_F00D_1234_5678, 1, 0, 32'hCAFE_F00D);

        // Squash in WAIT -> drain, then next load accepted the cycle after
        cyc(1, 32'h6000, 5'd3, 3'b010, 0, 0, 0, 64'h0, 0);
        cyc(0, 32'h6000, 5'd3, 3'b010, 0, 1, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 64'h0, 0);
        check("sqw_stall", lb_exec_stall, 1'b1);
        idle();
        check("drain_mem_req", mem_req, 1'b0);
        check("drain_cdb", cdb_valid, 1'b0);
        check("drain_stall", lb_exec_stall, 1'b1);
        cyc(1, 32'h7000, 5'd4, 3'b010, 0, 0, 1, 64'h0000_0000_0000_0001, 0);
        check("drain_no_accept", lb_exec_stall, 1'b1);
        cyc(1, 32'h7000, 5'd4, 3'b010, 0, 0, 0, 64'h0, 0);
        check("post_drain_cdb", cdb_valid, 1'b0);
        check("post_drain_accept", lb_exec_stall, 1'b0);
        cyc(0, 0, 0, 0, 0, 1, 0, 64'h0, 0);
        check("post_drain_addr", mem_addr, 32'h7000);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_0000_0042, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 64'h0, 1);
        check("post_drain_tag", cdb_tag, 5'd4);
        check("post_drain_value", cdb_value, 32'h42);
        idle();

        // Squash in REQ with grant -> drain consumes exactly one response
        cyc(1, 32'h8008, 5'd9, 3'b001, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_0000_FFFF, 0);
        check("sqr_drain_cdb", cdb_valid, 1'b0);
        check("sqr_drain_stall", lb_exec_stall, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_0000_FFFF, 0);
        check("sqr_idle_stall", lb_exec_stall, 1'b0);
        idle();
        check("sqr_extra_cdb", cdb_valid, 1'b0);
        do_load(32'h9001, 5'd10, 3'b100, 64'h0000_0000_0000_AB00, 0, 0, 32'h0000_00AB);

        // Squash in REQ without grant -> straight back to idle
        cyc(1, 32'hA000, 5'd11, 3'b010, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 64'h0, 0);
        check("sqr0_mem_req", mem_req, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_1111_1111, 0);
        check("sqr0_mem_req_off", mem_req, 1'b0);
        check("sqr0_stall", lb_exec_stall, 1'b0);
        idle();
        check("sqr0_cdb", cdb_valid, 1'b0);

        // Squash in BCAST without grant
        cyc(1, 32'hA100, 5'd12, 3'b010, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_1234_5678, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 64'h0, 0);
        check("sqb_valid", cdb_valid, 1'b1);
        idle();
        check("sqb_after_valid", cdb_valid, 1'b0);
        check("sqb_after_stall", lb_exec_stall, 1'b0);

        // Squash in BCAST together with grant counts as completed
        cyc(1, 32'hA200, 5'd13, 3'b000, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_0000_007F, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 64'h0, 1);
        check("sqbg_value", cdb_value, 32'h7F);
        idle();
        check("sqbg_after_valid", cdb_valid, 1'b0);

        // Squash in WAIT with response in the same cycle -> data discarded
        cyc(1, 32'hA300, 5'd14, 3'b010, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1, 64'h0000_0000_5555_5555, 0);
        idle();
        check("sqwr_cdb", cdb_valid, 1'b0);
        check("sqwr_stall", lb_exec_stall, 1'b0);

        // Squash in IDLE blocks acceptance
        cyc(1, 32'hA400, 5'd15, 3'b010, 1, 0, 0, 64'h0, 0);
        check("sqi_stall", lb_exec_stall, 1'b1);
        idle();
        check("sqi_mem_req", mem_req, 1'b0);

        // Reset during WAIT, then a stale response
        cyc(1, 32'hB004, 5'd12, 3'b010, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 64'h0, 0);
        idle();
        reset = 1;
        idle();
        reset = 0;
        check("rstw_mem_req", mem_req, 1'b0);
        check("rstw_mem_addr", mem_addr, 32'h0);
        check("rstw_cdb_valid", cdb_valid, 1'b0);
        check("rstw_cdb_tag", cdb_tag, 5'd0);
        check("rstw_cdb_value", cdb_value, 32'h0);
        check("rstw_stall", lb_exec_stall, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        idle();
        check("rstw_stale_cdb", cdb_valid, 1'b0);
        check("rstw_stale_stall", lb_exec_stall, 1'b0);
        idle();

        chk_en = 0;
        check("model_completions", m_done, 9);
        check("dut_completions", dut_done, 9);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
